// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset sequencer and the datapath muxes it steers.
// Opcodes, state codes, select codes and the per-state control word live here.
package multicycle_control_fsm_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;

   localparam logic [3:0] ST_FETCH    = 4'd0;
   localparam logic [3:0] ST_DECODE   = 4'd1;
   localparam logic [3:0] ST_EXEC_R   = 4'd2;
   localparam logic [3:0] ST_WB_R     = 4'd3;
   localparam logic [3:0] ST_EXEC_I   = 4'd4;
   localparam logic [3:0] ST_WB_I     = 4'd5;
   localparam logic [3:0] ST_LUI_WB   = 4'd6;
   localparam logic [3:0] ST_MEM_ADDR = 4'd7;
   localparam logic [3:0] ST_MEM_RD   = 4'd8;
   localparam logic [3:0] ST_MEM_WR   = 4'd9;
   localparam logic [3:0] ST_WB_MEM   = 4'd10;
   localparam logic [3:0] ST_BRANCH   = 4'd11;
   localparam logic [3:0] ST_JUMP     = 4'd12;
   localparam logic [3:0] ST_JAL      = 4'd13;

   typedef enum logic [3:0] {
      S_FETCH    = ST_FETCH,
      S_DECODE   = ST_DECODE,
      S_EXEC_R   = ST_EXEC_R,
      S_WB_R     = ST_WB_R,
      S_EXEC_I   = ST_EXEC_I,
      S_WB_I     = ST_WB_I,
      S_LUI_WB   = ST_LUI_WB,
      S_MEM_ADDR = ST_MEM_ADDR,
      S_MEM_RD   = ST_MEM_RD,
      S_MEM_WR   = ST_MEM_WR,
      S_WB_MEM   = ST_WB_MEM,
      S_BRANCH   = ST_BRANCH,
      S_JUMP     = ST_JUMP,
      S_JAL      = ST_JAL
   } state_e;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_OR    = 2'b10;
   localparam logic [1:0] ALU_FUNCT = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] DST_RT = 2'b00;
   localparam logic [1:0] DST_RD = 2'b01;
   localparam logic [1:0] DST_RA = 2'b10;

   localparam logic [1:0] M2R_ALUOUT = 2'b00;
   localparam logic [1:0] M2R_MDR    = 2'b01;
   localparam logic [1:0] M2R_PC     = 2'b10;
   localparam logic [1:0] M2R_LUI    = 2'b11;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       bne;
      logic [1:0] pc_source;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       reg_write;
   } ctl_t;

   typedef struct packed {
      logic rtype;
      logic lw;
      logic sw;
      logic branch;
      logic jump;
      logic jal;
      logic ori;
      logic lui;
      logic illegal;
   } op_class_t;

   // FETCH's pc_write/ir_write are raw here; the top qualifies them with mem_ready.
   function automatic ctl_t moore_ctl(input state_e st, input logic bne_sense);
      ctl_t c;
      c = '0;
      case (st)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.ir_write  = 1'b1;
            c.pc_write  = 1'b1;
            c.pc_source = PCSRC_ALU;
            c.alu_src_b = SRCB_FOUR;
            c.alu_op    = ALU_ADD;
         end
         S_DECODE: begin
            c.alu_src_b = SRCB_IMM_SH;
            c.alu_op    = ALU_ADD;
         end
         S_EXEC_R: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_RT;
            c.alu_op    = ALU_FUNCT;
         end
         S_WB_R: begin
            c.reg_dst    = DST_RD;
            c.mem_to_reg = M2R_ALUOUT;
            c.reg_write  = 1'b1;
         end
         S_EXEC_I: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALU_OR;
         end
         S_WB_I: begin
            c.reg_dst    = DST_RT;
            c.mem_to_reg = M2R_ALUOUT;
            c.reg_write  = 1'b1;
         end
         S_LUI_WB: begin
            c.reg_dst    = DST_RT;
            c.mem_to_reg = M2R_LUI;
            c.reg_write  = 1'b1;
         end
         S_MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALU_ADD;
         end
         S_MEM_RD: begin
            c.iord     = 1'b1;
            c.mem_read = 1'b1;
         end
         S_MEM_WR: begin
            c.iord      = 1'b1;
            c.mem_write = 1'b1;
         end
         S_WB_MEM: begin
            c.reg_dst    = DST_RT;
            c.mem_to_reg = M2R_MDR;
            c.reg_write  = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_src_b     = SRCB_RT;
            c.alu_op        = ALU_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_source     = PCSRC_ALUOUT;
            c.bne           = bne_sense;
         end
         S_JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = PCSRC_JUMP;
         end
         S_JAL: begin
            c.pc_write   = 1'b1;
            c.pc_source  = PCSRC_JUMP;
            c.reg_dst    = DST_RA;
            c.mem_to_reg = M2R_PC;
            c.reg_write  = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/control_opcode_decode.sv
// Combinational opcode classifier: one-hot instruction class plus an illegal flag.
module control_opcode_decode
   import multicycle_control_fsm_pkg::*;
(
   input  logic [5:0] opcode_i,
   output op_class_t  class_o
);

   // One class bit per recognised opcode; anything else is illegal.
   always_comb begin
      class_o = '0;
      case (opcode_i)
         OP_RTYPE:       class_o.rtype   = 1'b1;
         OP_LW:          class_o.lw      = 1'b1;
         OP_SW:          class_o.sw      = 1'b1;
         OP_BEQ, OP_BNE: class_o.branch  = 1'b1;
         OP_J:           class_o.jump    = 1'b1;
         OP_JAL:         class_o.jal     = 1'b1;
         OP_ORI:         class_o.ori     = 1'b1;
         OP_LUI:         class_o.lui     = 1'b1;
         default:        class_o.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle sequencer time-sharing one ALU and one memory port for the MIPS subset.
// The control word is registered from the next state; only the memory handshake gates it.
module multicycle_control_fsm
   import multicycle_control_fsm_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       bne,
   output logic [1:0] pc_source,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic       reg_write,
   output logic       illegal_op,
   output logic       mem_abort
);

   localparam logic [7:0] TIMEOUT_W = 8'(MEM_TIMEOUT);

   state_e     state_q, state_d;
   ctl_t       ctl_q, ctl_d;
   logic [7:0] wait_q, wait_d;
   op_class_t  cls_s;
   logic       ready_s, in_mem_s, abort_s;
   logic       unused_zero_s;

   // The branch decision (zero ^ bne) is formed in the datapath, not here.
   assign unused_zero_s = zero;

   control_opcode_decode u_decode (
      .opcode_i (opcode),
      .class_o  (cls_s)
   );

   assign ready_s  = mem_ready & ~reset;
   assign in_mem_s = ctl_q.mem_read | ctl_q.mem_write;
   assign abort_s  = in_mem_s & ~ready_s & (wait_q == TIMEOUT_W);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            if (abort_s)      state_d = S_FETCH;
            else if (ready_s) state_d = S_DECODE;
            else              state_d = S_FETCH;
         end
         S_DECODE: begin
            if (cls_s.rtype)               state_d = S_EXEC_R;
            else if (cls_s.lw || cls_s.sw) state_d = S_MEM_ADDR;
            else if (cls_s.branch)         state_d = S_BRANCH;
            else if (cls_s.jump)           state_d = S_JUMP;
            else if (cls_s.jal)            state_d = S_JAL;
            else if (cls_s.ori)            state_d = S_EXEC_I;
            else if (cls_s.lui)            state_d = S_LUI_WB;
            else                           state_d = S_FETCH;
         end
         S_EXEC_R: state_d = S_WB_R;
         S_EXEC_I: state_d = S_WB_I;
         S_MEM_ADDR: begin
            if (cls_s.sw) state_d = S_MEM_WR;
            else          state_d = S_MEM_RD;
         end
         S_MEM_RD: begin
            if (abort_s)      state_d = S_FETCH;
            else if (ready_s) state_d = S_WB_MEM;
            else              state_d = S_MEM_RD;
         end
         S_MEM_WR: begin
            if (abort_s || ready_s) state_d = S_FETCH;
            else                    state_d = S_MEM_WR;
         end
         S_WB_R, S_WB_I, S_LUI_WB, S_WB_MEM, S_BRANCH, S_JUMP, S_JAL: state_d = S_FETCH;
         default: state_d = S_FETCH;
      endcase
   end

   // Any state change (including an abort re-entering FETCH) restarts the watchdog.
   always_comb begin
      if (abort_s || (state_d != state_q)) wait_d = 8'd0;
      else if (in_mem_s && !ready_s)       wait_d = wait_q + 8'd1;
      else                                 wait_d = wait_q;
   end

   assign ctl_d = moore_ctl(state_d, opcode[0]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
         ctl_q   <= moore_ctl(S_FETCH, 1'b0);
         wait_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         ctl_q   <= ctl_d;
         wait_q  <= wait_d;
      end
   end

   assign pc_write      = ctl_q.pc_write & (~ctl_q.ir_write | ready_s);
   assign ir_write      = ctl_q.ir_write & ready_s;
   assign mem_read      = ctl_q.mem_read & ~abort_s;
   assign mem_write     = ctl_q.mem_write & ~abort_s;
   assign pc_write_cond = ctl_q.pc_write_cond;
   assign bne           = ctl_q.bne;
   assign pc_source     = ctl_q.pc_source;
   assign iord          = ctl_q.iord;
   assign alu_src_a     = ctl_q.alu_src_a;
   assign alu_src_b     = ctl_q.alu_src_b;
   assign alu_op        = ctl_q.alu_op;
   assign reg_dst       = ctl_q.reg_dst;
   assign mem_to_reg    = ctl_q.mem_to_reg;
   assign reg_write     = ctl_q.reg_write;
   assign illegal_op    = (state_q == S_DECODE) & cls_s.illegal;
   assign mem_abort     = abort_s;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: a per-cycle vector table plus reset/timeout sequences.
module tb_multicycle_control_fsm;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       bne;
      logic [1:0] pc_source;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       reg_write;
      logic       illegal_op;
      logic       mem_abort;
   } obs_t;

   typedef struct {
      logic [5:0] op;
      logic       zero;
      logic       rdy;
      obs_t       exp;
      string      name;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset, zero, mem_ready;
   logic [5:0] opcode;
   logic       pc_write, pc_write_cond, bne, iord, mem_read, mem_write, ir_write;
   logic       alu_src_a, reg_write, illegal_op, mem_abort;
   logic [1:0] pc_source, alu_src_b, alu_op, reg_dst, mem_to_reg;

   int errors = 0;
   int checks = 0;
   vec_t vecs[$];

   obs_t e_fetch, e_fstall, e_fabort, e_dec, e_dec_ill, e_exr, e_wbr, e_exi, e_wbi, e_lui;
   obs_t e_madr, e_mrd, e_wbm, e_mwr, e_mwr_abort, e_beq, e_bne, e_j, e_jal;

   always #5 clk = ~clk;

   multicycle_control_fsm #(.MEM_TIMEOUT(15)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .bne(bne), .pc_source(pc_source),
      .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal_op(illegal_op),
      .mem_abort(mem_abort)
   );

   function automatic obs_t sample();
      return {pc_write, pc_write_cond, bne, pc_source, iord, mem_read, mem_write, ir_write,
              alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, illegal_op, mem_abort};
   endfunction

   task automatic check(input string nm, input obs_t e);
      obs_t a;
      a = sample();
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask

   task automatic step(input logic [5:0] op, input logic z, input logic r, input obs_t e,
                       input string nm);
      @(negedge clk);
      opcode = op; zero = z; mem_ready = r;
      #1;
      check(nm, e);
   endtask

   task automatic add(input logic [5:0] op, input logic z, input logic r, input obs_t e,
                      input string nm);
      vec_t v;
      v.op = op; v.zero = z; v.rdy = r; v.exp = e; v.name = nm;
      vecs.push_back(v);
   endtask

   initial begin
      reset = 1'b1; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b1;

      e_fstall = '0; e_fstall.mem_read = 1'b1; e_fstall.alu_src_b = 2'b01;
      e_fetch = e_fstall; e_fetch.pc_write = 1'b1; e_fetch.ir_write = 1'b1;
      e_fabort = e_fstall; e_fabort.mem_read = 1'b0; e_fabort.mem_abort = 1'b1;
      e_dec = '0; e_dec.alu_src_b = 2'b11;
      e_dec_ill = e_dec; e_dec_ill.illegal_op = 1'b1;
      e_exr = '0; e_exr.alu_src_a = 1'b1; e_exr.alu_src_b = 2'b00; e_exr.alu_op = 2'b11;
      e_wbr = '0; e_wbr.reg_dst = 2'b01; e_wbr.reg_write = 1'b1;
      e_exi = '0; e_exi.alu_src_a = 1'b1; e_exi.alu_src_b = 2'b10; e_exi.alu_op = 2'b10;
      e_wbi = '0; e_wbi.reg_write = 1'b1;
      e_lui = '0; e_lui.mem_to_reg = 2'b11; e_lui.reg_write = 1'b1;
      e_madr = '0; e_madr.alu_src_a = 1'b1; e_madr.alu_src_b = 2'b10;
      e_mrd = '0; e_mrd.iord = 1'b1; e_mrd.mem_read = 1'b1;
      e_wbm = '0; e_wbm.mem_to_reg = 2'b01; e_wbm.reg_write = 1'b1;
      e_mwr = '0; e_mwr.iord = 1'b1; e_mwr.mem_write = 1'b1;
      e_mwr_abort = '0; e_mwr_abort.iord = 1'b1; e_mwr_abort.mem_abort = 1'b1;
      e_beq = '0; e_beq.pc_write_cond = 1'b1; e_beq.pc_source = 2'b01;
      e_beq.alu_src_a = 1'b1; e_beq.alu_op = 2'b01;
      e_bne = e_beq; e_bne.bne = 1'b1;
      e_j = '0; e_j.pc_write = 1'b1; e_j.pc_source = 2'b10;
      e_jal = e_j; e_jal.reg_dst = 2'b10; e_jal.mem_to_reg = 2'b10; e_jal.reg_write = 1'b1;

      add(6'b000000, 1'b0, 1'b1, e_fetch, "r_fetch");
      add(6'b000000, 1'b0, 1'b0, e_dec,   "r_decode");
      add(6'b000000, 1'b0, 1'b1, e_exr,   "r_exec");
      add(6'b000000, 1'b0, 1'b0, e_wbr,   "r_wb_cycle4");
      add(6'b001101, 1'b0, 1'b1, e_fetch, "ori_fetch");
      add(6'b001101, 1'b0, 1'b1, e_dec,   "ori_decode");
      add(6'b001101, 1'b0, 1'b0, e_exi,   "ori_exec");
      add(6'b001101, 1'b0, 1'b0, e_wbi,   "ori_wb");
      add(6'b001111, 1'b0, 1'b1, e_fetch, "lui_fetch");
      add(6'b001111, 1'b0, 1'b0, e_dec,   "lui_decode");
      add(6'b001111, 1'b0, 1'b1, e_lui,   "lui_wb");
      add(6'b101011, 1'b0, 1'b1, e_fetch, "sw_fetch");
      add(6'b101011, 1'b0, 1'b0, e_dec,   "sw_decode");
      add(6'b101011, 1'b0, 1'b1, e_madr,  "sw_addr");
      add(6'b101011, 1'b0, 1'b1, e_mwr,   "sw_write");
      add(6'b000100, 1'b1, 1'b1, e_fetch, "beq_fetch");
      add(6'b000100, 1'b1, 1'b0, e_dec,   "beq_decode");
      add(6'b000100, 1'b1, 1'b0, e_beq,   "beq_branch");
      add(6'b000010, 1'b0, 1'b1, e_fetch, "j_fetch");
      add(6'b000010, 1'b0, 1'b0, e_dec,   "j_decode");
      add(6'b000010, 1'b0, 1'b0, e_j,     "j_jump");
      add(6'b000101, 1'b0, 1'b1, e_fetch, "bne_fetch");
      add(6'b000101, 1'b0, 1'b0, e_dec,   "bne_decode");
      add(6'b000101, 1'b0, 1'b0, e_bne,   "bne_branch");
      add(6'b000011, 1'b0, 1'b1, e_fetch, "jal_fetch");
      add(6'b000011, 1'b0, 1'b0, e_dec,   "jal_decode");
      add(6'b000011, 1'b0, 1'b1, e_jal,   "jal_link");
      add(6'b100011, 1'b0, 1'b0, e_fstall, "fetch_stall");
      add(6'b100011, 1'b0, 1'b1, e_fetch, "lw_fetch");
      add(6'b100011, 1'b0, 1'b0, e_dec,   "lw_decode");
      add(6'b100011, 1'b0, 1'b1, e_madr,  "lw_addr");
      add(6'b100011, 1'b0, 1'b0, e_mrd,   "lw_stall1");
      add(6'b100011, 1'b0, 1'b0, e_mrd,   "lw_stall2");
      add(6'b100011, 1'b0, 1'b0, e_mrd,   "lw_stall3");
      add(6'b100011, 1'b0, 1'b1, e_mrd,   "lw_ready");
      add(6'b100011, 1'b0, 1'b0, e_wbm,   "lw_wb_cycle8");
      add(6'b101011, 1'b0, 1'b1, e_fetch, "sw2_fetch");
      add(6'b101011, 1'b0, 1'b0, e_dec,   "sw2_decode");
      add(6'b101011, 1'b0, 1'b0, e_madr,  "sw2_addr");
      add(6'b101011, 1'b0, 1'b0, e_mwr,   "sw2_stall1");
      add(6'b101011, 1'b0, 1'b0, e_mwr,   "sw2_stall2");
      add(6'b101011, 1'b0, 1'b1, e_mwr,   "sw2_ready");
      add(6'b000000, 1'b0, 1'b0, e_fstall, "sw2_back_fetch");

      #2;
      check("reset_hold", e_fstall);
      @(negedge clk);
      check("reset_after_edge", e_fstall);
      mem_ready = 1'b0;
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++)
         step(vecs[i].op, vecs[i].zero, vecs[i].rdy, vecs[i].exp, vecs[i].name);

      // Reset landing in a stalled load returns to FETCH at once.
      step(6'b100011, 1'b0, 1'b1, e_fetch, "rst1_fetch");
      step(6'b100011, 1'b0, 1'b0, e_dec,   "rst1_decode");
      step(6'b100011, 1'b0, 1'b0, e_madr,  "rst1_addr");
      step(6'b100011, 1'b0, 1'b0, e_mrd,   "rst1_stall");
      #1 reset = 1'b1;
      #1 check("rst_mid_mem_rd", e_fstall);
      @(negedge clk);
      check("rst_mid_mem_rd_held", e_fstall);
      reset = 1'b0;
      step(6'b100011, 1'b0, 1'b1, e_fetch, "rst1_refetch");
      step(6'b100011, 1'b0, 1'b0, e_dec,   "rst1_redecode");
      step(6'b100011, 1'b0, 1'b0, e_madr,  "rst2_addr");
      step(6'b100011, 1'b0, 1'b1, e_mrd,   "rst2_ready");
      step(6'b100011, 1'b0, 1'b0, e_wbm,   "rst2_wb");
      #1 reset = 1'b1;
      #1 check("rst_kills_reg_write", e_fstall);
      @(negedge clk);
      reset = 1'b0;

      // Illegal opcode, then a FETCH stall that runs the watchdog out.
      step(6'b111111, 1'b0, 1'b1, e_fetch,   "ill_fetch");
      step(6'b111111, 1'b0, 1'b0, e_dec_ill, "ill_decode");
      for (int k = 1; k <= 15; k++)
         step(6'b111111, 1'b0, 1'b0, e_fstall, $sformatf("fetch_wait_%0d", k));
      step(6'b111111, 1'b0, 1'b0, e_fabort, "fetch_abort_16");
      step(6'b111111, 1'b0, 1'b0, e_fstall, "fetch_after_abort");
      step(6'b101011, 1'b0, 1'b1, e_fetch,  "swto_fetch");
      step(6'b101011, 1'b0, 1'b0, e_dec,    "swto_decode");
      step(6'b101011, 1'b0, 1'b0, e_madr,   "swto_addr");
      for (int k = 1; k <= 15; k++)
         step(6'b101011, 1'b0, 1'b0, e_mwr, $sformatf("mwr_wait_%0d", k));
      step(6'b101011, 1'b0, 1'b0, e_mwr_abort, "mwr_abort_16");
      step(6'b101011, 1'b0, 1'b0, e_fstall,    "mwr_abort_to_fetch");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
